// File: rtl/robo_pkg.sv
// Shared types and default timing for the cleaning-robot actuator controller.
package robo_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        AVANCO,
        GIRO,
        BRACO_SAI,
        VARRE,
        BRACO_VOLTA,
        PARADA
    } estado_t;

    typedef enum logic [1:0] {
        CMD_NENHUM  = 2'b00,
        CMD_AVANCAR = 2'b01,
        CMD_GIRAR   = 2'b10,
        CMD_REMOVER = 2'b11
    } comando_t;

    localparam int unsigned AVANCO_CICLOS_PADRAO = 8;
    localparam int unsigned GIRO_CICLOS_PADRAO   = 16;
    localparam int unsigned BRACO_CICLOS_PADRAO  = 4;
    localparam int unsigned VARRE_CICLOS_PADRAO  = 8;

    // Counter load for an N-cycle hold: N-1, with 0 treated as 1 and saturating at 256 cycles.
    function automatic logic [7:0] carga_contador(input int unsigned n);
        if (n <= 1) begin
            return 8'd0;
        end else if (n >= 256) begin
            return 8'hFF;
        end else begin
            return 8'(n - 1);
        end
    endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// 8-bit loadable down-counter; stops at zero and flags it.
module temporizador_ciclos (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [7:0] valor,
    output logic       zero
);

    logic [7:0] contagem;

    // Load takes precedence; otherwise count down until zero is reached.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (carrega) begin
            contagem <= valor;
        end else if (contagem != '0) begin
            contagem <= contagem - 8'd1;
        end
    end

    assign zero = (contagem == '0);

endmodule

// File: rtl/controle_atuadores.sv
// Actuator sequencer: motor moves, arm/brush removal sequence and emergency stop.
module controle_atuadores
    import robo_pkg::*;
#(
    parameter int unsigned AVANCO_CICLOS = AVANCO_CICLOS_PADRAO,
    parameter int unsigned GIRO_CICLOS   = GIRO_CICLOS_PADRAO,
    parameter int unsigned BRACO_CICLOS  = BRACO_CICLOS_PADRAO,
    parameter int unsigned VARRE_CICLOS  = VARRE_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       avancar,
    input  logic       girar,
    input  logic       remover,
    input  logic       parar,
    output logic       motor_esq_frente,
    output logic       motor_dir_frente,
    output logic       motor_dir_re,
    output logic       braco_estende,
    output logic       braco_recolhe,
    output logic       escova_liga,
    output logic       ocupado,
    output logic       concluido,
    output logic [1:0] comando
);

    localparam logic [7:0] CARGA_AVANCO = carga_contador(AVANCO_CICLOS);
    localparam logic [7:0] CARGA_GIRO   = carga_contador(GIRO_CICLOS);
    localparam logic [7:0] CARGA_BRACO  = carga_contador(BRACO_CICLOS);
    localparam logic [7:0] CARGA_VARRE  = carga_contador(VARRE_CICLOS);

    estado_t    estado;
    estado_t    proximo;
    logic       abortado;
    logic       proximo_abortado;
    logic       carrega;
    logic [7:0] valor_carga;
    logic       zero;

    temporizador_ciclos u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (carrega),
        .valor   (valor_carga),
        .zero    (zero)
    );

    function automatic comando_t comando_do_estado(input estado_t e);
        case (e)
            AVANCO:                        return CMD_AVANCAR;
            GIRO:                          return CMD_GIRAR;
            BRACO_SAI, VARRE, BRACO_VOLTA: return CMD_REMOVER;
            default:                       return CMD_NENHUM;
        endcase
    endfunction

    // Next state, abort flag and timer load; a stop during the arm sequence still retracts first.
    always_comb begin
        proximo          = estado;
        proximo_abortado = abortado;
        carrega          = 1'b0;
        valor_carga      = '0;
        unique case (estado)
            OCIOSO: begin
                proximo_abortado = 1'b0;
                if (parar) begin
                    proximo = PARADA;
                end else if (remover) begin
                    proximo     = BRACO_SAI;
                    carrega     = 1'b1;
                    valor_carga = CARGA_BRACO;
                end else if (girar) begin
                    proximo     = GIRO;
                    carrega     = 1'b1;
                    valor_carga = CARGA_GIRO;
                end else if (avancar) begin
                    proximo     = AVANCO;
                    carrega     = 1'b1;
                    valor_carga = CARGA_AVANCO;
                end
            end
            AVANCO, GIRO: begin
                if (parar) begin
                    proximo = PARADA;
                end else if (zero) begin
                    proximo = OCIOSO;
                end
            end
            BRACO_SAI, VARRE: begin
                if (parar) begin
                    proximo          = BRACO_VOLTA;
                    proximo_abortado = 1'b1;
                    carrega          = 1'b1;
                    valor_carga      = CARGA_BRACO;
                end else if (zero) begin
                    carrega = 1'b1;
                    if (estado == BRACO_SAI) begin
                        proximo     = VARRE;
                        valor_carga = CARGA_VARRE;
                    end else begin
                        proximo     = BRACO_VOLTA;
                        valor_carga = CARGA_BRACO;
                    end
                end
            end
            BRACO_VOLTA: begin
                if (parar) begin
                    proximo_abortado = 1'b1;
                end
                if (zero) begin
                    proximo          = (abortado || parar) ? PARADA : OCIOSO;
                    proximo_abortado = 1'b0;
                end
            end
            PARADA: begin
                proximo_abortado = 1'b0;
                if (!parar) begin
                    proximo = OCIOSO;
                end
            end
            default: begin
                proximo          = OCIOSO;
                proximo_abortado = 1'b0;
            end
        endcase
    end

    // State register with Moore outputs decoded from the incoming state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado           <= OCIOSO;
            abortado         <= 1'b0;
            motor_esq_frente <= 1'b0;
            motor_dir_frente <= 1'b0;
            motor_dir_re     <= 1'b0;
            braco_estende    <= 1'b0;
            braco_recolhe    <= 1'b0;
            escova_liga      <= 1'b0;
            ocupado          <= 1'b0;
            concluido        <= 1'b0;
            comando          <= CMD_NENHUM;
        end else begin
            estado           <= proximo;
            abortado         <= proximo_abortado;
            motor_esq_frente <= (proximo == AVANCO) || (proximo == GIRO);
            motor_dir_frente <= (proximo == AVANCO);
            motor_dir_re     <= (proximo == GIRO);
            braco_estende    <= (proximo == BRACO_SAI);
            braco_recolhe    <= (proximo == BRACO_VOLTA);
            escova_liga      <= (proximo == VARRE);
            ocupado          <= (proximo != OCIOSO);
            // Only normal completions reach OCIOSO from a busy state other than PARADA.
            concluido        <= (proximo == OCIOSO) && (estado != OCIOSO) && (estado != PARADA);
            comando          <= comando_do_estado(proximo);
        end
    end

endmodule

// File: tb/tb_controle_atuadores.sv
// Self-checking bench for controle_atuadores: vector table, directed corner cases, random vs. model.
module tb_controle_atuadores;

    // Observation vector: {ocupado, concluido, comando[1:0], esq_frente, dir_frente, dir_re, estende, recolhe, escova}
    localparam logic [9:0] V_IDLE   = 10'b0_0_00_000000;
    localparam logic [9:0] V_FWD    = 10'b1_0_01_110000;
    localparam logic [9:0] V_TURN   = 10'b1_0_10_101000;
    localparam logic [9:0] V_EST    = 10'b1_0_11_000100;
    localparam logic [9:0] V_ESC    = 10'b1_0_11_000001;
    localparam logic [9:0] V_REC    = 10'b1_0_11_000010;
    localparam logic [9:0] V_PULSO  = 10'b0_1_00_000000;
    localparam logic [9:0] V_PARADA = 10'b1_0_00_000000;

    localparam int unsigned N_AVANCO = 8;
    localparam int unsigned N_GIRO   = 16;
    localparam int unsigned N_BRACO  = 4;
    localparam int unsigned N_VARRE  = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic avancar = 1'b0, girar = 1'b0, remover = 1'b0, parar = 1'b0;
    logic me, mdf, mdr, be, br, el, oc, co;
    logic [1:0] cmd;
    logic girar0 = 1'b0, nulo0 = 1'b0;
    logic me0, mdf0, mdr0, be0, br0, el0, oc0, co0;
    logic [1:0] cmd0;
    logic [9:0] obs, obs0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    controle_atuadores dut (
        .clock(clock), .reset(reset),
        .avancar(avancar), .girar(girar), .remover(remover), .parar(parar),
        .motor_esq_frente(me), .motor_dir_frente(mdf), .motor_dir_re(mdr),
        .braco_estende(be), .braco_recolhe(br), .escova_liga(el),
        .ocupado(oc), .concluido(co), .comando(cmd)
    );

    controle_atuadores #(.GIRO_CICLOS(0)) dut0 (
        .clock(clock), .reset(reset),
        .avancar(nulo0), .girar(girar0), .remover(nulo0), .parar(nulo0),
        .motor_esq_frente(me0), .motor_dir_frente(mdf0), .motor_dir_re(mdr0),
        .braco_estende(be0), .braco_recolhe(br0), .escova_liga(el0),
        .ocupado(oc0), .concluido(co0), .comando(cmd0)
    );

    assign obs  = {oc, co, cmd, me, mdf, mdr, be, br, el};
    assign obs0 = {oc0, co0, cmd0, me0, mdf0, mdr0, be0, br0, el0};

    task automatic verifica(input string nome, input logic [9:0] obtido, input logic [9:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    // Drive inputs just after a falling edge, let the rising edge sample them, return at the next falling edge.
    task automatic ciclo(input logic a, input logic g, input logic r, input logic p);
        avancar = a; girar = g; remover = r; parar = p;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic trecho(input string nome, input int unsigned n, input logic p, input logic [9:0] esp);
        for (int unsigned i = 0; i < n; i++) begin
            ciclo(1'b0, 1'b0, 1'b0, p);
            verifica(nome, obs, esp);
        end
    endtask

    typedef struct {
        logic       a;
        logic       g;
        logic       r;
        logic       p;
        logic [9:0] esp;
    } vetor_t;
    vetor_t tabela[$];

    task automatic poe(input logic a, input logic g, input logic r, input logic p,
                       input logic [9:0] esp, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tabela.push_back('{a, g, r, p, esp});
    endtask

    // Reference model: a queue of expected output vectors planned when a command is accepted.
    // Kind tags: 0 idle, 1 motion, 2 arm out/brush, 3 arm back, 4 completion pulse, 5 stopped.
    typedef struct {
        logic [9:0] v;
        int         k;
    } passo_t;
    passo_t plano[$];
    int atual_k = 0;

    task automatic agenda(input logic [9:0] v, input int k, input int unsigned n);
        int unsigned m;
        m = (n == 0) ? 1 : n;
        for (int unsigned i = 0; i < m; i++) plano.push_back('{v, k});
    endtask

    task automatic modelo(input logic a, input logic g, input logic r, input logic p, output logic [9:0] esp);
        passo_t e;
        if (atual_k == 0 || atual_k == 4) begin
            plano.delete();
            if (p) agenda(V_PARADA, 5, 1);
            else if (r) begin
                agenda(V_EST, 2, N_BRACO);
                agenda(V_ESC, 2, N_VARRE);
                agenda(V_REC, 3, N_BRACO);
                agenda(V_PULSO, 4, 1);
            end
            else if (g) begin agenda(V_TURN, 1, N_GIRO); agenda(V_PULSO, 4, 1); end
            else if (a) begin agenda(V_FWD, 1, N_AVANCO); agenda(V_PULSO, 4, 1); end
            else agenda(V_IDLE, 0, 1);
        end else if (atual_k == 5) begin
            plano.delete();
            if (p) agenda(V_PARADA, 5, 1);
            else agenda(V_IDLE, 0, 1);
        end else if (p) begin
            if (atual_k == 1) begin
                plano.delete();
                agenda(V_PARADA, 5, 1);
            end else if (atual_k == 2) begin
                plano.delete();
                agenda(V_REC, 3, N_BRACO);
                agenda(V_PARADA, 5, 1);
            end else begin
                void'(plano.pop_back());
                agenda(V_PARADA, 5, 1);
            end
        end
        e = plano.pop_front();
        atual_k = e.k;
        esp = e.v;
    endtask

    initial begin
        logic [9:0] esp;
        logic a, g, r, p;

        // Reset state
        #1;
        verifica("reset", obs, V_IDLE);
        verifica("reset_giro0", obs0, V_IDLE);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        verifica("pos_reset", obs, V_IDLE);

        // Forward pulse, girar ignored during AVANCO, stop from idle
        poe(1, 0, 0, 0, V_FWD, 1);
        poe(0, 0, 0, 0, V_FWD, N_AVANCO - 1);
        poe(0, 0, 0, 0, V_PULSO, 1);
        poe(0, 0, 0, 0, V_IDLE, 1);
        poe(1, 0, 0, 0, V_FWD, 1);
        poe(0, 1, 0, 0, V_FWD, N_AVANCO - 1);
        poe(0, 1, 0, 0, V_PULSO, 1);
        poe(0, 0, 0, 0, V_IDLE, 2);
        poe(0, 0, 0, 1, V_PARADA, 2);
        poe(0, 0, 0, 0, V_IDLE, 2);
        foreach (tabela[i]) begin
            ciclo(tabela[i].a, tabela[i].g, tabela[i].r, tabela[i].p);
            verifica($sformatf("tabela[%0d]", i), obs, tabela[i].esp);
        end

        // All three requests together: remover wins
        ciclo(1, 1, 1, 0);
        verifica("prio_estende", obs, V_EST);
        trecho("prio_estende", N_BRACO - 1, 1'b0, V_EST);
        trecho("prio_varre", N_VARRE, 1'b0, V_ESC);
        trecho("prio_recolhe", N_BRACO, 1'b0, V_REC);
        trecho("prio_concluido", 1, 1'b0, V_PULSO);
        trecho("prio_ocioso", 1, 1'b0, V_IDLE);

        // Stop in the 3rd VARRE cycle: full retract, PARADA, no completion pulse
        ciclo(0, 0, 1, 0);
        verifica("abort_estende", obs, V_EST);
        trecho("abort_estende", N_BRACO - 1, 1'b0, V_EST);
        trecho("abort_varre", 3, 1'b0, V_ESC);
        trecho("abort_recolhe", N_BRACO, 1'b1, V_REC);
        trecho("abort_parada", 2, 1'b1, V_PARADA);
        trecho("abort_ocioso", 2, 1'b0, V_IDLE);

        // Asynchronous reset in the middle of GIRO
        ciclo(0, 1, 0, 0);
        verifica("giro", obs, V_TURN);
        trecho("giro", 2, 1'b0, V_TURN);
        #2 reset = 1'b0;
        #1 verifica("reset_assinc", obs, V_IDLE);
        @(negedge clock);
        reset = 1'b1;
        verifica("reset_liberado", obs, V_IDLE);
        trecho("reset_ocioso", 1, 1'b0, V_IDLE);

        // GIRO_CICLOS = 0 behaves as a single cycle
        girar0 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        girar0 = 1'b0;
        verifica("giro0_ciclo", obs0, V_TURN);
        @(posedge clock);
        @(negedge clock);
        verifica("giro0_concluido", obs0, V_PULSO);
        @(posedge clock);
        @(negedge clock);
        verifica("giro0_ocioso", obs0, V_IDLE);

        // Random traffic against the reference model
        atual_k = 0;
        plano.delete();
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 3) == 0);
            g = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 19) == 0);
            modelo(a, g, r, p, esp);
            ciclo(a, g, r, p);
            verifica("aleatorio", obs, esp);
            verifica("exclusao", {8'b0, mdf & mdr, be & br}, 10'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_atuadores.md
CONTROLE_ATUADORES -- requirements
Module: controle_atuadores

Interface
REQ-001 SHALL have parameter AVANCO_CICLOS, default 8, cycles the motors drive forward per avancar command.
REQ-002 SHALL have parameter GIRO_CICLOS, default 16, cycles of in-place rotation per girar command.
REQ-003 SHALL have parameter BRACO_CICLOS, default 4, cycles for each arm extend or retract phase.
REQ-004 SHALL have parameter VARRE_CICLOS, default 8, cycles the brush runs with the arm extended.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-007 SHALL have ports avancar, girar, remover, input, 1 each, level requests from the navigation FSM.
REQ-008 SHALL have port parar, input, 1, emergency stop from the under/cliff sensor path.
REQ-009 SHALL have ports motor_esq_frente, motor_dir_frente, motor_dir_re, output, 1 each, motor drive.
REQ-010 SHALL have ports braco_estende, braco_recolhe, escova_liga, output, 1 each, arm and brush drive.
REQ-011 SHALL have port ocupado, output, 1, high in every state except OCIOSO.
REQ-012 SHALL have port concluido, output, 1, a one-cycle pulse on normal command completion.
REQ-013 SHALL have port comando, output, 2, the command in progress: 00 none, 01 avancar, 10 girar, 11 remover.

Function
REQ-014 SHALL implement states OCIOSO, AVANCO, GIRO, BRACO_SAI, VARRE, BRACO_VOLTA and PARADA.
REQ-015 SHALL sample requests only in OCIOSO, with priority parar > remover > girar > avancar; requests in other states are ignored, never queued.
REQ-016 SHALL, on the edge that samples a request in OCIOSO, enter the target state, so outputs assert in the next cycle (latency 1).
REQ-017 SHALL register all outputs as a pure function of the state (Moore).
REQ-018 SHALL hold each timed state for exactly N cycles, using an 8-bit down-counter loaded with N-1 on entry; a parameter value of 0 is treated as 1.
REQ-019 SHALL drive outputs per state as follows.
- AVANCO: motor_esq_frente=1 and motor_dir_frente=1.
- GIRO: motor_esq_frente=1 and motor_dir_re=1.
- BRACO_SAI: braco_estende=1.
- VARRE: escova_liga=1.
- BRACO_VOLTA: braco_recolhe=1.
- All other outputs are 0 in every state.
REQ-020 SHALL make transitions on counter expiry as follows.
- AVANCO and GIRO go to OCIOSO.
- BRACO_SAI goes to VARRE.
- VARRE goes to BRACO_VOLTA.
- BRACO_VOLTA goes to OCIOSO, or to PARADA when the sequence was aborted.
REQ-021 SHALL pulse concluido in the first OCIOSO cycle after a command that was not aborted.
REQ-022 SHALL, when parar=1, take the following action by state.
- AVANCO, GIRO or OCIOSO: go to PARADA on the next edge.
- BRACO_SAI or VARRE: go to BRACO_VOLTA with a full BRACO_CICLOS count, set an abort flag, then go to PARADA.
- BRACO_VOLTA: finish retracting, then go to PARADA.
REQ-023 SHALL hold PARADA, with all actuator outputs 0, while parar=1, then go to OCIOSO on the first edge with parar=0, without pulsing concluido.
REQ-024 SHALL keep comando at the value of the aborted command through BRACO_VOLTA, and drive 00 in PARADA and OCIOSO.
REQ-025 SHALL never assert motor_dir_frente together with motor_dir_re, nor braco_estende together with braco_recolhe.

Reset
REQ-026 SHALL, while reset=0, immediately force state OCIOSO, counter 0, abort flag 0 and all outputs 0, including ocupado, concluido and comando=00.
REQ-027 SHALL leave the arm position unspecified after reset; re-homing is the navigation FSM's responsibility via a remover command.

Structure
REQ-028 SHALL place the state enum, the comando encoding and the default cycle constants in a shared package, robo_pkg.
REQ-029 SHALL use a single sub-module, temporizador_ciclos: an 8-bit loadable down-counter with a zero flag.

Verification
REQ-030 SHALL cover: avancar=1 for one cycle in OCIOSO -> both forward motors high for exactly 8 cycles starting 1 cycle later, then concluido pulsed once.
REQ-031 SHALL cover: avancar, girar and remover all high together -> remover sequence runs as 4 cycles extend, 8 cycles brush, 4 cycles retract, with comando=11 throughout.
REQ-032 SHALL cover: parar asserted in the 3rd VARRE cycle -> BRACO_VOLTA for 4 cycles, then PARADA, and no concluido pulse.
REQ-033 SHALL cover: girar raised during AVANCO -> ignored; after AVANCO completes with girar low, the FSM stays in OCIOSO.
REQ-034 SHALL cover: reset driven low mid-GIRO, asynchronous to clock -> all outputs 0 before the next edge, and OCIOSO after release.
REQ-035 SHALL cover: GIRO_CICLOS=0 -> GIRO lasts exactly 1 cycle.
